// File: rtl/fcl1_mac.sv
// fcl1_mac: FCL1 layer, NOUT neurons evaluated serially on one MAC fed by an external weight/bias ROM.
// Define FCL1_RELU_EN to clamp negative results to zero at the output.
module fcl1_mac #(
    parameter int NOUT = 10,
    parameter int AW   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [111:0]         in_FCL1_1,
    input  logic [111:0]         in_FCL1_2,
    input  logic [111:0]         in_FCL1_3,
    input  logic [111:0]         in_FCL1_4,
    output logic [AW-1:0]        w_addr,
    input  logic signed [15:0]   w_data,
    output logic                 busy,
    output logic                 out_valid,
    output logic [3:0]           out_idx,
    output logic [15:0]          out_data,
    output logic                 done
);
    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT} state_t;
    localparam logic [AW-1:0] BIAS_BASE = AW'(28 * NOUT);
    localparam logic [3:0]    LAST      = 4'(NOUT - 1);
    state_t               r_state;
    logic [0:27][15:0]    r_act;
    logic [3:0]           r_n;
    logic [4:0]           r_i;
    logic [AW-1:0]        r_base;
    logic signed [39:0]   r_acc;
    logic [4:0]           w_ai;
    logic signed [15:0]   w_sel;
    logic signed [31:0]   w_prod;
    logic signed [39:0]   w_sum;
    logic signed [39:0]   w_sh;
    logic                 w_fits;
    logic [15:0]          w_sat;
    logic [15:0]          w_res;
    // ROM data lags the address by one cycle, so the product pairs with the previous index
    assign w_ai   = (r_state == S_DRAIN || r_i == 5'd0) ? 5'd27 : r_i - 5'd1;
    assign w_sel  = r_act[w_ai];
    assign w_prod = w_data * w_sel;
    assign w_sum  = r_acc + {{8{w_prod[31]}}, w_prod};
    assign w_sh   = w_sum >>> 8;
    assign w_fits = &w_sh[39:15] | ~|w_sh[39:15];
    assign w_sat  = w_fits ? w_sh[15:0] : (w_sh[39] ? 16'h8000 : 16'h7FFF);
`ifdef FCL1_RELU_EN
    assign w_res  = w_sat[15] ? 16'h0000 : w_sat;
`else
    assign w_res  = w_sat;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_act     <= '0;
            r_n       <= '0;
            r_i       <= '0;
            r_base    <= '0;
            r_acc     <= '0;
            w_addr    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_act   <= {in_FCL1_1, in_FCL1_2, in_FCL1_3, in_FCL1_4};
                    r_n     <= '0;
                    r_base  <= '0;
                    w_addr  <= BIAS_BASE;
                    busy    <= 1'b1;
                    r_state <= S_BIAS;
                end
                S_BIAS: begin
                    w_addr  <= r_base;
                    r_i     <= '0;
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc   <= (r_i == 5'd0) ? {{16{w_data[15]}}, w_data, 8'h00} : w_sum;
                    r_i     <= r_i + 5'd1;
                    w_addr  <= (r_i == 5'd27) ? w_addr : w_addr + AW'(1);
                    r_state <= (r_i == 5'd27) ? S_DRAIN : S_MAC;
                end
                S_DRAIN: begin
                    r_acc     <= w_sum;
                    out_valid <= 1'b1;
                    out_idx   <= r_n;
                    out_data  <= w_res;
                    done      <= (r_n == LAST);
                    r_state   <= S_OUT;
                end
                S_OUT: if (r_n == LAST) begin
                    busy    <= 1'b0;
                    w_addr  <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_n     <= r_n + 4'd1;
                    r_base  <= r_base + AW'(28);
                    w_addr  <= BIAS_BASE + AW'(r_n + 4'd1);
                    r_state <= S_BIAS;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fcl1_mac.sv
// tb_fcl1_mac: directed vector bench for fcl1_mac with a behavioural synchronous ROM.
module tb_fcl1_mac;
    localparam int NOUT = 10;
    localparam int AW   = 9;
`ifdef FCL1_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [111:0]  in_FCL1_1 = '0, in_FCL1_2 = '0, in_FCL1_3 = '0, in_FCL1_4 = '0;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data = '0;
    logic          busy, out_valid, done;
    logic [3:0]    out_idx;
    logic [15:0]   out_data;
    logic [15:0]   rom [512];
    logic [15:0]   exp_d [NOUT];
    int            n_cmp = 0;
    int            n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] e;
    } vec_t;
    vec_t tbl [8];

    fcl1_mac #(.NOUT(NOUT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_FCL1_1(in_FCL1_1), .in_FCL1_2(in_FCL1_2), .in_FCL1_3(in_FCL1_3), .in_FCL1_4(in_FCL1_4),
        .w_addr(w_addr), .w_data(w_data), .busy(busy), .out_valid(out_valid),
        .out_idx(out_idx), .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) w_data <= rom[w_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_act(input logic [447:0] a);
        {in_FCL1_1, in_FCL1_2, in_FCL1_3, in_FCL1_4} = a;
    endtask

    task automatic fill(input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < 512; k++) rom[k] = 16'h0000;
        for (int k = 0; k < 28 * NOUT; k++) rom[k] = w;
        for (int k = 0; k < NOUT; k++) rom[28 * NOUT + k] = b;
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
        return (RELU && v[15]) ? 16'h0000 : v;
    endfunction

    // mode 0: plain run, 1: start+input change at cycle 100, 2: rst at cycle 75
    task automatic run(input int mode);
        int nv;
        bit killed, ev, eb;
        int n;
        nv = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 31 * NOUT + 2; c++) begin
            killed = (mode == 2) && (c > 75);
            ev = (c % 31 == 0) && (c / 31 <= NOUT) && !killed;
            eb = (c <= 31 * NOUT) && !killed;
            n  = c / 31 - 1;
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(ev && n == NOUT - 1));
            if (ev) begin
                chk("out_idx", 32'(out_idx), 32'(n));
                chk("out_data", 32'(out_data), 32'(exp_d[n]));
            end
            if (out_valid) nv++;
            if (mode != 2 || c < 75) begin
                if (c == 1)  chk("w_addr_bias0", 32'(w_addr), 280);
                if (c == 2)  chk("w_addr_mac0", 32'(w_addr), 0);
                if (c == 29) chk("w_addr_mac27", 32'(w_addr), 27);
                if (c == 32) chk("w_addr_bias1", 32'(w_addr), 281);
                if (c == 33) chk("w_addr_n1_mac0", 32'(w_addr), 28);
                if (c == 40) chk("out_data_hold", 32'(out_data), 32'(exp_d[0]));
            end
            if (mode == 2 && c == 76) begin
                chk("rst_out_data", 32'(out_data), 0);
                chk("rst_out_idx", 32'(out_idx), 0);
                chk("rst_w_addr", 32'(w_addr), 0);
            end
            if (mode == 1 && c == 100) begin
                start = 1'b1;
                set_act({28{16'h0200}});
            end
            if (mode == 1 && c == 101) start = 1'b0;
            if (mode == 2 && c == 75) rst = 1'b1;
            if (mode == 2 && c == 76) rst = 1'b0;
            @(negedge clk);
        end
        chk("pulse_count", 32'(nv), (mode == 2) ? 2 : NOUT);
    endtask

    initial begin
        tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h1C00};
        tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
        tbl[2] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000};
        tbl[3] = '{16'h0080, 16'hFF00, 16'h0200, 16'hF400};
        tbl[4] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
        tbl[5] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[6] = '{16'h0100, 16'h0100, 16'h7F00, 16'h7FFF};
        tbl[7] = '{16'h0000, 16'h0000, 16'h8000, 16'h8000};
        fill(16'h0100, 16'h0000);
        set_act({28{16'h0100}});
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", 32'(busy), 0);
            chk("reset_out_valid", 32'(out_valid), 0);
            chk("reset_done", 32'(done), 0);
            chk("reset_out_data", 32'(out_data), 0);
            chk("reset_out_idx", 32'(out_idx), 0);
            chk("reset_w_addr", 32'(w_addr), 0);
            @(negedge clk);
        end
        for (int r = 0; r < 8; r++) begin
            set_act({28{tbl[r].a}});
            fill(tbl[r].w, tbl[r].b);
            for (int n = 0; n < NOUT; n++) exp_d[n] = relu(tbl[r].e);
            run(0);
        end
        set_act('0);
        in_FCL1_3[79:64] = 16'h0200;
        fill(16'h0300, 16'h0080);
        for (int n = 0; n < NOUT; n++) begin
            rom[28 * n + 16] = 16'(16'h0100 * (n + 1));
            exp_d[n] = 16'(16'h0200 * (n + 1) + 16'h0080);
        end
        run(0);
        set_act({28{16'h0100}});
        fill(16'h0100, 16'h0000);
        for (int n = 0; n < NOUT; n++) exp_d[n] = 16'h1C00;
        run(1);
        set_act({28{16'h0100}});
        run(2);
        run(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fcl1_mac.md
# fcl1_mac

First fully connected layer (FCL1) of the CNN inference pipeline. It sits directly downstream of the pool2-to-FCL1 register stage and consumes its four 112-bit feature vectors (28 signed 16-bit activations in total). It computes NOUT neuron outputs serially on a single multiply-accumulate unit, fetching weights and biases from an external synchronous ROM. Results stream out one neuron per handshake pulse.

## Interface

Parameters:
- NOUT, 10, number of output neurons (1..16)
- AW, 9, weight ROM address width; must satisfy 2^AW ≥ 29·NOUT

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a layer evaluation
- in_FCL1_1 … in_FCL1_4  in  112 each  feature vectors, 7 signed Q8.8 elements each
- w_addr  out  AW  weight/bias ROM address
- w_data  in  16  signed Q8.8 ROM data, valid one cycle after w_addr
- busy  out  1  evaluation in progress
- out_valid  out  1  one-cycle pulse, out_data/out_idx valid
- out_idx  out  4  neuron index of out_data
- out_data  out  16  signed Q8.8 neuron result
- done  out  1  one-cycle pulse with last out_valid

## Operation

- Element j (0..6) of in_FCL1_k is bits [111-16j -: 16]; input index i = 7(k-1)+j, 0..27.
- Weight for neuron n, input i at address 28n+i; bias for neuron n at address 28·NOUT+n.
- start sampled only in IDLE: all four vectors latched internally on that edge; later input changes ignored until next start. start while busy ignored.
- FSM: IDLE → BIAS → MAC → DRAIN → OUT → (BIAS for n+1 | IDLE after n=NOUT-1).
  - BIAS (1 cycle): w_addr = bias address of n.
  - MAC (28 cycles, i=0..27): w_addr = 28n+i; first cycle loads acc ← sign-extended bias <<< 8; subsequent cycles accumulate product of previous weight.
  - DRAIN (1 cycle): accumulate product for i=27.
  - OUT (1 cycle): out_valid=1, out_idx=n, out_data = result.
- Arithmetic: product 16×16 signed → 32-bit Q16.16; accumulator 40-bit signed, no internal overflow possible. Result = acc >>> 8 (arithmetic, truncation), saturated to [0x8000, 0x7FFF].
- w_addr = 0 in IDLE.

## Timing

- Reset values: busy=0, out_valid=0, done=0, out_idx=0, out_data=0, w_addr=0, FSM=IDLE, neuron counter 0.
- Edge E0 samples start. busy=1 from cycle after E0 through the last OUT cycle inclusive.
- 31 cycles per neuron: out_valid for neuron n in cycle 31(n+1) after E0; done coincides with out_valid for n=NOUT-1; busy drops the following cycle.
- New start accepted in the cycle busy is 0 (earliest 31·NOUT+1 cycles after E0).
- out_data/out_idx hold last value between pulses.
- rst mid-operation: next cycle all outputs at reset values, no out_valid/done emitted, partial results discarded.
- rst and start in same cycle: rst wins, start dropped.

## Configuration

- FCL1_RELU_EN defined: after saturation, negative results are replaced by 0x0000 (ReLU fused into layer).
- Undefined: signed saturated result output unchanged; ReLU applied downstream.

## Test plan

- Reset: assert rst 2 cycles → all outputs 0, busy=0; start during rst → no activity.
- All inputs 0x0100, all weights 0x0100, biases 0, NOUT=10 → out_data=0x1C00 for idx 0..9 at cycles 31,62,…,310; done with idx 9.
- Ordering: only in_FCL1_3 element 2 (bits [79:64]) = 0x0200, weight at 28n+16 = 0x0100·(n+1), bias 0x0080 → out_data = 0x0200·(n+1)+0x0080.
- Saturation: inputs 0x7FFF, weights 0x7FFF → 0x7FFF; inputs 0x7FFF, weights 0x8000 → 0x8000 without FCL1_RELU_EN, 0x0000 with it.
- start pulsed again at cycle 100 and input vectors changed mid-run → ignored; results match first latched vectors; exactly 10 out_valid pulses.
- rst at cycle 75 → no further out_valid/done; fresh start afterwards produces full correct 10-result sequence.
